// File: rtl/example_mac_acc.sv
// -----------------------------------------------------------------------------
// example_mac_acc
//   Accumulates a group of signed products from an upstream multiplier and
//   emits one rounded, scaled result per group. A group ends after N_TERMS
//   products, or earlier on a transfer that carries in_last. The result is
//   (sum + 2^(SHIFT-1)) >>> SHIFT, i.e. round half up, and appears on
//   out_valid one cycle after the last product. The result is held until it
//   is taken with out_ready. No new products are accepted while a result is
//   pending.
//
// Configuration macro:
//   EXAMPLE_MAC_ACC_SAT_EN  defined   : clip result to DOUT_WIDTH range and
//                                       flag clipping on out_sat
//                           undefined : keep the low DOUT_WIDTH bits of the
//                                       result (wrap); out_sat is always 0
//
// Ports:
//   ap_clk     in   1           clock, all state on rising edge
//   ap_rst_n   in   1           asynchronous active-low reset
//   in_data    in   DIN_WIDTH   signed product
//   in_valid   in   1           product valid
//   in_last    in   1           early end of group
//   in_ready   out  1           product accepted this cycle (only in S_ACC)
//   out_data   out  DOUT_WIDTH  signed result
//   out_sat    out  1           result was clipped
//   out_valid  out  1           result valid
//   out_ready  in   1           downstream takes result
// -----------------------------------------------------------------------------
module example_mac_acc #(
    parameter int DIN_WIDTH  = 21,
    parameter int ACC_WIDTH  = 28,
    parameter int DOUT_WIDTH = 16,
    parameter int N_TERMS    = 8,
    parameter int SHIFT      = 5
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic signed [DIN_WIDTH-1:0]  in_data,
    input  logic                         in_valid,
    input  logic                         in_last,
    output logic                         in_ready,
    output logic signed [DOUT_WIDTH-1:0] out_data,
    output logic                         out_sat,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int CNT_W = $clog2(N_TERMS) + 1;
    // One extra bit so the rounding constant can never overflow the sum.
    localparam int RW    = ACC_WIDTH + 1;
    localparam logic [RW-1:0] ROUND = RW'(1) << (SHIFT - 1);

    typedef enum logic {
        S_ACC = 1'b0,
        S_OUT = 1'b1
    } state_t;

    state_t                         state_q, state_d;
    logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic        [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [DOUT_WIDTH-1:0]   out_data_q, out_data_d;
    logic                           out_sat_q, out_sat_d;
    logic                           out_valid_q, out_valid_d;

    logic signed [ACC_WIDTH-1:0]    sum;
    logic signed [RW-1:0]           rnd;
    logic signed [DOUT_WIDTH-1:0]   res_data;
    logic                           res_sat;
    logic                           is_last;

    assign in_ready  = (state_q == S_ACC);
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign out_valid = out_valid_q;

    assign is_last = in_last || (cnt_q == CNT_W'(N_TERMS - 1));

    // Final sum including the product on the input this cycle; ACC_WIDTH is
    // sized so this addition cannot overflow over a full group.
    assign sum = acc_q + {{(ACC_WIDTH - DIN_WIDTH){in_data[DIN_WIDTH-1]}}, in_data};
    assign rnd = {sum[ACC_WIDTH-1], sum} + ROUND;

`ifdef EXAMPLE_MAC_ACC_SAT_EN
    // Wide enough to hold both the shifted sum and the output range plus a
    // sign bit, so the range test below is a plain sign-bit comparison.
    localparam int EW = ((RW > DOUT_WIDTH) ? RW : DOUT_WIDTH) + 1;

    logic signed [EW-1:0]           r_ext;
    logic        [EW-DOUT_WIDTH:0]  r_top;
    logic                           r_fits;

    always_comb begin
        r_ext  = EW'(rnd >>> SHIFT);
        // The value fits DOUT_WIDTH iff every bit from the output sign bit
        // upward is a copy of that sign bit.
        r_top  = r_ext[EW-1:DOUT_WIDTH-1];
        r_fits = (&r_top) | ~(|r_top);
        if (r_fits) begin
            res_data = r_ext[DOUT_WIDTH-1:0];
            res_sat  = 1'b0;
        end else begin
            res_data = r_ext[EW-1] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}}
                                   : {1'b0, {(DOUT_WIDTH-1){1'b1}}};
            res_sat  = 1'b1;
        end
    end
`else
    always_comb begin
        res_data = DOUT_WIDTH'(rnd >>> SHIFT);
        res_sat  = 1'b0;
    end
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            S_ACC: begin
                if (in_valid) begin
                    acc_d = sum;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (is_last) begin
                        state_d     = S_OUT;
                        out_valid_d = 1'b1;
                        out_data_d  = res_data;
                        out_sat_d   = res_sat;
                    end
                end
            end
            S_OUT: begin
                // Inputs are ignored here; only the output handshake matters.
                if (out_ready) begin
                    state_d     = S_ACC;
                    acc_d       = '0;
                    cnt_d       = '0;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = S_ACC;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its input from before the edge, independent of statement order.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= S_ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_example_mac_acc.sv
module tb_example_mac_acc;

    localparam int DIN_WIDTH  = 21;
    localparam int ACC_WIDTH  = 28;
    localparam int DOUT_WIDTH = 16;
    localparam int N_TERMS    = 8;
    localparam int SHIFT      = 5;

    logic                         ap_clk = 1'b0;
    logic                         ap_rst_n = 1'b0;
    logic signed [DIN_WIDTH-1:0]  in_data = '0;
    logic                         in_valid = 1'b0;
    logic                         in_last = 1'b0;
    logic                         in_ready;
    logic signed [DOUT_WIDTH-1:0] out_data;
    logic                         out_sat;
    logic                         out_valid;
    logic                         out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    example_mac_acc #(
        .DIN_WIDTH (DIN_WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .DOUT_WIDTH(DOUT_WIDTH),
        .N_TERMS   (N_TERMS),
        .SHIFT     (SHIFT)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_sat  (out_sat),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        string name;
        int    din;
        int    n;
        bit    use_last;
        int    exp_data;
        int    exp_sat;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: exact integer sum, floor((sum + 2^(SHIFT-1)) / 2^SHIFT),
    // then clip or wrap to a DOUT_WIDTH signed value.
    function automatic void model(input longint sum, output int d, output int s);
        longint half = 1;
        longint r;
        longint lim = 1;
        half = half << (SHIFT - 1);
        lim  = lim << (DOUT_WIDTH - 1);
        r    = (sum + half) >>> SHIFT;
`ifdef EXAMPLE_MAC_ACC_SAT_EN
        if (r > lim - 1) begin
            d = int'(lim - 1); s = 1;
        end else if (r < -lim) begin
            d = int'(-lim); s = 1;
        end else begin
            d = int'(r); s = 0;
        end
`else
        r = r % (2 * lim);
        if (r < 0) r += 2 * lim;
        if (r >= lim) r -= 2 * lim;
        d = int'(r);
        s = 0;
`endif
    endfunction

    // Drive one product after `gap` idle cycles; returns 1 ns after the edge
    // that performs the transfer.
    task automatic push(input int d, input bit l, input int gap);
        int w;
        repeat (gap) @(negedge ap_clk);
        @(negedge ap_clk);
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge ap_clk);
            w++;
        end
        if (!in_ready) check("in_ready_wait", 0, 1);
        in_valid = 1'b1;
        in_data  = DIN_WIDTH'(d);
        in_last  = l;
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Output side of a group: latency-1 result check, optional stall, handshake.
    task automatic finish_group(input string name, input int exp_d, input int exp_s,
                                input int hold);
        check({name, "_valid"}, out_valid, 1);
        check({name, "_data"}, out_data, exp_d);
        check({name, "_sat"}, out_sat, exp_s);
        check({name, "_in_ready_low"}, in_ready, 0);
        repeat (hold) @(negedge ap_clk);
        @(negedge ap_clk);
        out_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        out_ready = 1'b0;
        check({name, "_valid_clr"}, out_valid, 0);
        check({name, "_in_ready_back"}, in_ready, 1);
    endtask

    task automatic run_group(input string name, input int vals[$], input bit last_on_end,
                             input int exp_d, input int exp_s, input int max_gap,
                             input int hold);
        for (int i = 0; i < vals.size(); i++) begin
            push(vals[i], last_on_end && (i == vals.size() - 1),
                 (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
            if (i < vals.size() - 1) check({name, "_early_valid"}, out_valid, 0);
        end
        finish_group(name, exp_d, exp_s, hold);
    endtask

    task automatic pulse_reset();
        @(negedge ap_clk);
        #2;
        ap_rst_n = 1'b0;
        #1;
        check("rst_async_valid", out_valid, 0);
        check("rst_async_data", out_data, 0);
        check("rst_async_sat", out_sat, 0);
        check("rst_async_in_ready", in_ready, 1);
        #1;
        ap_rst_n = 1'b1;
    endtask

    initial begin
        vec_t vecs[8];
        int   q[$];
        int   ed, es;
        longint sum;

`ifdef EXAMPLE_MAC_ACC_SAT_EN
        vecs[3] = '{"max8", 1048575, 8, 1'b0, 32767, 1};
        vecs[4] = '{"min8", -1048576, 8, 1'b0, -32768, 1};
`else
        vecs[3] = '{"max8", 1048575, 8, 1'b0, 0, 0};
        vecs[4] = '{"min8", -1048576, 8, 1'b0, 0, 0};
`endif
        vecs[0] = '{"c100x8", 100, 8, 1'b0, 25, 0};
        vecs[1] = '{"c32x3_last", 32, 3, 1'b1, 3, 0};
        vecs[2] = '{"c100x8_after_last", 100, 8, 1'b0, 25, 0};
        vecs[5] = '{"neg1x8", -1, 8, 1'b0, 0, 0};
        vecs[6] = '{"c100x2_last", 100, 2, 1'b1, 6, 0};
        vecs[7] = '{"one_x1_last", 1, 1, 1'b1, 0, 0};

        // Reset state
        #3;
        check("reset_valid", out_valid, 0);
        check("reset_data", out_data, 0);
        check("reset_sat", out_sat, 0);
        check("reset_in_ready", in_ready, 1);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;

        // Directed table
        foreach (vecs[k]) begin
            q.delete();
            for (int i = 0; i < vecs[k].n; i++) q.push_back(vecs[k].din);
            run_group(vecs[k].name, q, vecs[k].use_last, vecs[k].exp_data,
                      vecs[k].exp_sat, 0, 0);
        end

        // Result held for 5 cycles while junk products are offered
        for (int i = 0; i < 8; i++) push(100, 1'b0, 0);
        check("hold_valid", out_valid, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge ap_clk);
            in_valid = 1'b1;
            in_data  = DIN_WIDTH'(12345);
            in_last  = 1'b1;
            @(posedge ap_clk);
            #1;
            check("hold_data", out_data, 25);
            check("hold_valid_stable", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        finish_group("hold", 25, 0, 0);
        q.delete();
        for (int i = 0; i < 8; i++) q.push_back(100);
        run_group("after_hold", q, 1'b0, 25, 0, 0, 0);

        // Reset while a result is pending, then mid-group
        for (int i = 0; i < 8; i++) push(100, 1'b0, 0);
        check("pre_rst_valid", out_valid, 1);
        pulse_reset();
        for (int i = 0; i < 4; i++) push(100, 1'b0, 0);
        pulse_reset();
        run_group("after_rst", q, 1'b0, 25, 0, 0, 0);

        // Randomized groups against the reference model
        for (int g = 0; g < 40; g++) begin
            int  len;
            bit  lst;
            len = int'($urandom_range(1, N_TERMS));
            lst = (len < N_TERMS) ? 1'b1 : 1'($urandom_range(0, 1));
            q.delete();
            sum = 0;
            for (int i = 0; i < len; i++) begin
                int v;
                v = int'($urandom_range(0, (1 << DIN_WIDTH) - 1)) - (1 << (DIN_WIDTH - 1));
                if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 200)) - 100;
                q.push_back(v);
                sum += v;
            end
            model(sum, ed, es);
            run_group($sformatf("rand%0d", g), q, lst, ed, es, 2,
                      int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
